rr_mux_arb: RTL and testbench

- Parametrised N-channel registered multiplexer with round-robin arbitration and valid/ready handshake on every channel.
- Generational successor to the combinational 2:1 mux. Adds configurable channel count and width, fair arbitration, backpressure and a registered output.
- Sits between multiple producers and a single shared consumer, such as a shared bus or output port.

---
 rtl/rr_mux_arb.sv | 78 +++++++
 tb/tb_rr_mux_arb.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arb.sv
// N_CH-input registered mux with round-robin arbitration and valid/ready on every channel.
// Define RR_MUX_ARB_FIXED_PRIO_EN for fixed priority, where the lowest valid index always wins.
module rr_mux_arb #(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    input  logic                  out_ready
);

    logic             load_ok;
    logic             gnt_vld;
    logic [SEL_W-1:0] gnt_idx;
    logic [SEL_W-1:0] base;
    logic             xfer;

`ifdef RR_MUX_ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [SEL_W-1:0] ptr;
    assign base = ptr;
`endif

    assign load_ok = !out_valid || out_ready;

    // Search starts at base and wraps, so the first hit is the highest-priority channel.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (!gnt_vld && in_valid[(int'(base) + k) % N_CH]) begin
                gnt_vld = 1'b1;
                gnt_idx = SEL_W'((int'(base) + k) % N_CH);
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (!rst && load_ok && gnt_vld)
            in_ready[gnt_idx] = 1'b1;
    end

    assign xfer = |in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(gnt_idx)*WIDTH +: WIDTH];
            out_sel   <= gnt_idx;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifndef RR_MUX_ARB_FIXED_PRIO_EN
    // The pointer moves only on an input transfer, to the channel after the winner.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (xfer)
            ptr <= (gnt_idx == SEL_W'(N_CH-1)) ? '0 : gnt_idx + 1'b1;
    end
`endif

endmodule

// File: tb/tb_rr_mux_arb.sv
// Randomized plus directed bench for rr_mux_arb; a spec-level model feeds a scoreboard queue.
module tb_rr_mux_arb;
    localparam int N_CH  = 4;
    localparam int WIDTH = 8;
    localparam int SEL_W = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_sel;
    logic                  out_ready;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [WIDTH-1:0] d;
        int               s;
    } exp_t;
    exp_t sbq[$];

    int m_ptr  = 0;
    bit m_full = 1'b0;

    rr_mux_arb #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: evaluates the arbitration rules on the inputs seen this cycle.
    always @(negedge clk) begin
        logic [N_CH-1:0] exp_rdy;
        int g;
        int b;
        exp_rdy = '0;
        g = -1;
        if (rst) begin
            chk("rst_in_ready", in_ready, '0);
            sbq.delete();
            m_ptr  = 0;
            m_full = 1'b0;
        end else begin
            chk("out_valid", out_valid, m_full);
`ifdef RR_MUX_ARB_FIXED_PRIO_EN
            b = 0;
`else
            b = m_ptr;
`endif
            if (!m_full || out_ready)
                for (int k = 0; k < N_CH; k++)
                    if (g < 0 && in_valid[(b + k) % N_CH] === 1'b1) g = (b + k) % N_CH;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("in_ready", in_ready, exp_rdy);
            if (g >= 0) begin
                sbq.push_back('{in_data[g*WIDTH +: WIDTH], g});
                m_ptr  = (g + 1) % N_CH;
                m_full = 1'b1;
            end else if (m_full && out_ready) begin
                m_full = 1'b0;
            end
        end
    end

    // Monitor: compares each word the consumer accepts, and watches stall stability.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid === 1'b1 && out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty at %0t: actual=word required=none", $time);
            end else begin
                e = sbq.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_sel", out_sel, e.s);
            end
        end
    end

    always @(negedge clk) begin
        logic             stall;
        logic [WIDTH-1:0] sd;
        logic [SEL_W-1:0] ss;
        if (!rst && stall === 1'b1) begin
            chk("stall_data", out_data, sd);
            chk("stall_sel", out_sel, ss);
        end
        stall = !rst && out_valid && !out_ready;
        sd = out_data;
        ss = out_sel;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_data_seq();
        for (int i = 0; i < N_CH; i++) in_data[i*WIDTH +: WIDTH] = 8'h10 + 8'(i);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = '1;
        out_ready = 1'b1;
        set_data_seq();
        cyc(2);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data", out_data, 8'h00);
        chk("reset_out_sel", out_sel, 0);

        // single channel
        rst = 1'b0;
        in_valid = 4'b0100;
        in_data[2*WIDTH +: WIDTH] = 8'hA5;
        cyc(1);
        chk("single_valid", out_valid, 1'b1);
        chk("single_data", out_data, 8'hA5);
        chk("single_sel", out_sel, 2);
        in_valid = '0;
        cyc(1);

        // fairness from reset
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        set_data_seq();
        in_valid = '1;
        cyc(6);

        // backpressure on a word from ch1 (0x11)
        in_valid = 4'b0010;
        cyc(1);
        out_ready = 1'b0;
        in_valid = '1;
        cyc(3);
        out_ready = 1'b1;
        cyc(2);

        // wrap-around and skip
        in_valid = 4'b1000;
        cyc(1);
        in_valid = 4'b0110;
        cyc(2);
        in_valid = 4'b0001;
        cyc(1);

        // mid-operation reset while stalled
        out_ready = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(1);
        chk("midrst_out_valid", out_valid, 1'b0);
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid = '1;
        cyc(1);
        chk("midrst_first_sel", out_sel, 0);
        cyc(2);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = N_CH'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 299) == 0);
            cyc(1);
        end

        rst = 1'b0;
        in_valid = '0;
        out_ready = 1'b1;
        cyc(3);
        chk("drain_empty", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
